// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction-fetch front end with a DEPTH-entry prefetch
// buffer. It tolerates IM_LAT-cycle memory latency and downstream back-pressure,
// redirects on a taken branch and stops issuing once a halt instruction returns.
module fetch_prefetch_unit #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IM_LAT   = 1,
    parameter logic [4:0]  HALT_OPC = 5'b11111
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IMclka,
    output logic              IMena,
    output logic [ADDR_W-1:0] IMaddra,
    input  logic [DATA_W-1:0] IMdouta,
    input  logic              stall_IFOF,
    input  logic              isBranchTaken,
    input  logic [ADDR_W-1:0] branchPC,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              valid,
    output logic              stop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + IM_LAT + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [IM_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0] pipe_addr_q [IM_LAT];
    logic [ADDR_W-1:0] pipe_addr_d [IM_LAT];
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_data_q [DEPTH];
    logic [ADDR_W-1:0] buf_addr_q [DEPTH];

    logic [PW:0]       occ;
    logic [CW-1:0]     inflight;
    logic [PW-1:0]     head;
    logic              empty, full, credit;
    logic              ret_vld, ret_halt, issue, push, pop;
    logic [ADDR_W-1:0] ret_addr;

    assign IMclka  = clk;
    assign IMena   = issue;
    assign IMaddra = pc_q;

    // Buffer status, issue credit, return decode and head presentation.
    always_comb begin
        occ      = wr_ptr_q - rd_ptr_q;
        empty    = (occ == '0);
        full     = occ[PW];
        inflight = '0;
        for (int unsigned i = 0; i < IM_LAT; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
        credit   = (CW'(occ) + inflight) < CW'(DEPTH);
        ret_vld  = pipe_vld_q[IM_LAT-1];
        ret_addr = pipe_addr_q[IM_LAT-1];
        // A halt returning this cycle already blocks issue, so nothing past it is fetched.
        ret_halt = ret_vld && (IMdouta[DATA_W-1 -: 5] == HALT_OPC);
        issue    = rst && !halted_q && !ret_halt && !isBranchTaken && credit;
        push     = ret_vld && !isBranchTaken;
        head     = rd_ptr_q[PW-1:0];
        valid    = !empty;
        inst     = valid ? buf_data_q[head] : '0;
        pc       = valid ? buf_addr_q[head] : '0;
        stop     = valid && (inst[DATA_W-1 -: 5] == HALT_OPC);
        pop      = valid && !stall_IFOF;
    end

    // Next-state: fetch PC, halt flag, in-flight pipe and buffer pointers; redirect wins.
    always_comb begin
        pc_d           = pc_q + ADDR_W'(issue);
        halted_d       = halted_q | ret_halt;
        wr_ptr_d       = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d       = rd_ptr_q + (PW+1)'(pop);
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = issue;
        pipe_addr_d[0] = pc_q;
        for (int unsigned i = 1; i < IM_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
        if (isBranchTaken) begin
            pc_d       = branchPC;
            halted_d   = 1'b0;
            pipe_vld_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Control state register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            halted_q   <= 1'b0;
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < IM_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int unsigned i = 0; i < IM_LAT; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    // Buffer storage; contents are only observed behind valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q[PW-1:0]] <= IMdouta;
            buf_addr_q[wr_ptr_q[PW-1:0]] <= ret_addr;
        end
    end

    // The issue credit check must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule
